mmio_led_pwm: RTL and testbench

Parametrised memory-mapped LED/GPIO output controller on the CPU data port, alongside RAM in the SoC address decoder. Generalises a single 8-bit LED register to N_CH channels with atomic set/clear/toggle writes, per-channel PWM brightness, a programmable prescaler and glitch-free duty updates. Reads are combinational, so the CPU reads back in the same cycle.

---
 rtl/mmio_led_pwm_if.sv | 12 +
 rtl/mmio_led_pwm.sv | 107 ++++++++++
 tb/tb_mmio_led_pwm.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_led_pwm_if.sv
// CPU data-port bundle for the memory-mapped LED/PWM block.
// The master drives the address, write data and write strobe. The slave returns read data and its window select.
interface mmio_led_pwm_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wenable;
  logic [31:0] rdata;
  logic        sel;

  modport master (output addr, output wdata, output wenable, input rdata, input sel);
  modport slave  (input addr, input wdata, input wenable, output rdata, output sel);
endinterface

// File: rtl/mmio_led_pwm.sv
// N_CH-channel LED controller with atomic set/clear/toggle writes and per-channel PWM.
// A prescaler sets the PWM rate, and duty updates are double-buffered. Reads are combinational.
module mmio_led_pwm #(
  parameter int          N_CH       = 8,
  parameter int          PWM_BITS   = 8,
  parameter int          PRESC_BITS = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            reset_n,
  mmio_led_pwm_if.slave   bus,
  output logic [N_CH-1:0] led
);

  localparam logic [PRESC_BITS-1:0] PRESC_ONE = 1;
  localparam logic [PWM_BITS-1:0]   PWM_ONE   = 1;

  logic [5:0]            word;
  logic                  wr;
  logic                  unused_wdata;
  logic [N_CH-1:0]       out_q, out_d, en_q, ch;
  logic [PRESC_BITS-1:0] presc_q, presc_cnt;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic [PWM_BITS-1:0]   shadow_q [N_CH];
  logic [PWM_BITS-1:0]   shadow_d [N_CH];
  logic [PWM_BITS-1:0]   active_q [N_CH];
  logic                  tick, wrap;

  assign word         = bus.addr[7:2];
  assign bus.sel      = ((bus.addr & ~32'hFF) == BASE_ADDR);
  assign wr           = bus.wenable & bus.sel;
  assign unused_wdata = ^bus.wdata;

  assign tick = (presc_cnt == presc_q);
  assign wrap = tick & (&pwm_cnt);

  always_comb begin
    out_d = out_q;
    if (wr) begin
      case (word)
        6'd0:    out_d = bus.wdata[N_CH-1:0];
        6'd1:    out_d = out_q | bus.wdata[N_CH-1:0];
        6'd2:    out_d = out_q & ~bus.wdata[N_CH-1:0];
        6'd3:    out_d = out_q ^ bus.wdata[N_CH-1:0];
        default: out_d = out_q;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      shadow_d[i] = shadow_q[i];
      if (wr && word == 6'(16 + i))
        shadow_d[i] = bus.wdata[PWM_BITS-1:0];
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++)
      ch[i] = out_q[i] & (en_q[i] ? (pwm_cnt < active_q[i]) : 1'b1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q     <= '0;
      en_q      <= '0;
      presc_q   <= '0;
      presc_cnt <= '0;
      pwm_cnt   <= '0;
      led       <= '0;
      for (int i = 0; i < N_CH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      out_q <= out_d;
      if (wr && word == 6'd4) en_q <= bus.wdata[N_CH-1:0];
      if (wr && word == 6'd5) presc_q <= bus.wdata[PRESC_BITS-1:0];
      if ((wr && word == 6'd5) || tick) presc_cnt <= '0;
      else                              presc_cnt <= presc_cnt + PRESC_ONE;
      if (tick) pwm_cnt <= pwm_cnt + PWM_ONE;
      // Loading from shadow_d lets a duty write on the wrap edge land in the new period.
      for (int i = 0; i < N_CH; i++) begin
        shadow_q[i] <= shadow_d[i];
        if (wrap || !en_q[i]) active_q[i] <= shadow_d[i];
      end
      led <= ch;
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.sel) begin
      case (word)
        6'd0, 6'd1, 6'd2, 6'd3: bus.rdata = 32'(out_q);
        6'd4:                   bus.rdata = 32'(en_q);
        6'd5:                   bus.rdata = 32'(presc_q);
        6'd6:                   bus.rdata = 32'(pwm_cnt);
        default: begin
          for (int i = 0; i < N_CH; i++)
            if (word == 6'(16 + i)) bus.rdata = 32'(shadow_q[i]);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_led_pwm.sv
// Directed and random checks of mmio_led_pwm against a register-level reference model.
module tb_mmio_led_pwm;
  localparam int          N    = 8;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic         clk_25mhz = 1'b0;
  logic         reset_n;
  logic [N-1:0] led;
  int           n_checks = 0;
  int           n_errors = 0;

  mmio_led_pwm_if bus ();

  mmio_led_pwm #(.N_CH(N), .PWM_BITS(8), .PRESC_BITS(16), .BASE_ADDR(BASE)) dut (
    .clk     (clk_25mhz),
    .reset_n (reset_n),
    .bus     (bus),
    .led     (led)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  // Reference model: register contents and counters as plain integers.
  logic [N-1:0] m_out, m_en, m_led;
  int           m_presc, m_pc, m_pwm;
  int           m_shadow [N];
  int           m_active [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_out = '0; m_en = '0; m_led = '0;
    m_presc = 0; m_pc = 0; m_pwm = 0;
    for (int i = 0; i < N; i++) begin
      m_shadow[i] = 0;
      m_active[i] = 0;
    end
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int off;
    if ((a & ~32'hFF) != BASE) return 32'h0;
    off = int'(a[7:0]) & 'hFC;
    if (off <= 'h0C) return 32'(m_out);
    if (off == 'h10) return 32'(m_en);
    if (off == 'h14) return 32'(m_presc);
    if (off == 'h18) return 32'(m_pwm);
    if (off >= 'h40 && off < 'h40 + 4 * N) return 32'(m_shadow[(off - 'h40) / 4]);
    return 32'h0;
  endfunction

  // One rising edge: the LED shows the pre-edge channel value, then the write and counters advance.
  function automatic void m_clock(input logic [31:0] a, input logic [31:0] d, input logic we);
    logic [N-1:0] ch, old_en;
    bit tick, wrap, pw;
    int off;
    for (int i = 0; i < N; i++)
      ch[i] = m_out[i] & (m_en[i] ? (m_pwm < m_active[i]) : 1'b1);
    tick = (m_pc == m_presc);
    wrap = tick && (m_pwm == 255);
    old_en = m_en;
    pw = 0;
    if (we && (a & ~32'hFF) == BASE) begin
      off = int'(a[7:0]) & 'hFC;
      case (off)
        'h00: m_out = d[N-1:0];
        'h04: m_out = m_out | d[N-1:0];
        'h08: m_out = m_out & ~d[N-1:0];
        'h0C: m_out = m_out ^ d[N-1:0];
        'h10: m_en = d[N-1:0];
        'h14: begin m_presc = int'(d[15:0]); pw = 1; end
        default: if (off >= 'h40 && off < 'h40 + 4 * N) m_shadow[(off - 'h40) / 4] = int'(d[7:0]);
      endcase
    end
    for (int i = 0; i < N; i++)
      if (wrap || !old_en[i]) m_active[i] = m_shadow[i];
    m_pc = (pw || tick) ? 0 : m_pc + 1;
    if (tick) m_pwm = (m_pwm + 1) % 256;
    m_led = ch;
  endfunction

  task automatic step();
    @(posedge clk_25mhz);
    if (reset_n) m_clock(bus.addr, bus.wdata, bus.wenable);
    @(negedge clk_25mhz);
    chk("led", 32'(led), 32'(m_led));
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr = a; bus.wdata = d; bus.wenable = 1'b1;
    step();
    bus.wenable = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a);
    bus.addr = a; bus.wenable = 1'b0;
    #1;
    chk(tag, bus.rdata, m_read(a));
    chk({tag, "_sel"}, 32'(bus.sel), 32'((a & ~32'hFF) == BASE));
  endtask

  initial begin : main
    int hi, s0, guard;
    logic [N-1:0] saved;
    logic [31:0] a, d;
    reset_n = 1'b0;
    bus.addr = BASE; bus.wdata = '0; bus.wenable = 1'b0;
    m_reset();

    // Reset held with the clock running
    repeat (3) step();
    chk("rst_led", 32'(led), 32'h0);
    rd("rst_rd", BASE);
    chk("rst_rd_zero", bus.rdata, 32'h0);
    reset_n = 1'b1;
    step();

    // Atomic set/clear/toggle
    wr(BASE + 32'h00, 32'hF0); rd("out_wr", BASE); chk("out_f0", bus.rdata, 32'hF0);
    wr(BASE + 32'h04, 32'h0F); rd("out_set", BASE + 32'h04); chk("out_ff", bus.rdata, 32'hFF);
    wr(BASE + 32'h08, 32'h81); rd("out_clr", BASE + 32'h08); chk("out_7e", bus.rdata, 32'h7E);
    wr(BASE + 32'h0C, 32'h03); rd("out_tgl", BASE + 32'h0C); chk("out_7d", bus.rdata, 32'h7D);
    step();
    chk("led_7d", 32'(led), 32'h7D);

    // PWM with PRESCALE=0, duty 64
    wr(BASE + 32'h14, 32'h0);
    wr(BASE + 32'h40, 32'd64);
    wr(BASE + 32'h10, 32'h01);
    wr(BASE + 32'h00, 32'h01);
    repeat (300) step();
    hi = 0;
    for (int k = 0; k < 256; k++) begin step(); hi += int'(led[0]); end
    chk("pwm_hi64", 32'(hi), 32'd64);
    hi = 0;
    for (int k = 0; k < 256; k++) begin step(); hi += int'(led[0]); end
    chk("pwm_hi64_again", 32'(hi), 32'd64);

    // Mid-period duty change is deferred to the next period
    guard = 0;
    while (m_pwm != 100 && guard < 300) begin step(); guard++; end
    chk("reach_cnt100", 32'(m_pwm), 32'd100);
    rd("status100", BASE + 32'h18);
    wr(BASE + 32'h40, 32'd200);
    hi = 0; guard = 0;
    while (m_pwm != 0 && guard < 300) begin step(); hi += int'(led[0]); guard++; end
    chk("keep64_rest", 32'(hi), 32'd0);
    hi = 0;
    for (int k = 0; k < 256; k++) begin step(); hi += int'(led[0]); end
    chk("next_hi200", 32'(hi), 32'd200);

    // Disabled channel takes duty immediately
    wr(BASE + 32'h10, 32'h00);
    wr(BASE + 32'h40, 32'd50);
    repeat (5) step();
    wr(BASE + 32'h10, 32'h01);
    repeat (20) step();

    // Prescaler 3: counter advances every 4 cycles, period 1024
    wr(BASE + 32'h14, 32'd3);
    rd("presc_rd", BASE + 32'h14);
    bus.addr = BASE + 32'h18; #1; s0 = int'(bus.rdata);
    chk("status_a", bus.rdata, m_read(BASE + 32'h18));
    repeat (4) step();
    rd("status_b", BASE + 32'h18);
    chk("status_inc1", 32'((int'(bus.rdata) - s0) & 'hFF), 32'd1);
    repeat (2) step();
    wr(BASE + 32'h14, 32'd3);
    for (int k = 0; k < 9; k++) begin rd("status_rw", BASE + 32'h18); step(); end
    hi = 0;
    for (int k = 0; k < 1024; k++) begin step(); hi += int'(led[0]); end
    chk("presc_hi200", 32'(hi), 32'd200);

    // Decode boundaries
    saved = m_out;
    bus.addr = 32'h8000_0100; #1;
    chk("oob_sel", 32'(bus.sel), 32'h0);
    chk("oob_rdata", bus.rdata, 32'h0);
    wr(32'h8000_0100, 32'hFFFF_FFFF);
    rd("oob_out", BASE);
    chk("oob_nochg", bus.rdata, 32'(saved));
    wr(BASE + 32'h40 + 4 * N, 32'hFF);
    rd("duty_n", BASE + 32'h40 + 4 * N);
    chk("duty_n_zero", bus.rdata, 32'h0);
    rd("low_addr", 32'h0000_0010);
    chk("low_sel", 32'(bus.sel), 32'h0);
    chk("low_rdata", bus.rdata, 32'h0);

    // Random traffic over the register window
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 13))
        0: a = BASE + 32'h00;  1: a = BASE + 32'h04;  2: a = BASE + 32'h08;
        3: a = BASE + 32'h0C;  4: a = BASE + 32'h10;  5: a = BASE + 32'h14;
        6: a = BASE + 32'h18;  7: a = BASE + 32'h1C;  8: a = BASE + 32'h60;
        9: a = 32'h8000_0100;  10: a = 32'h0000_0010;
        default: a = BASE + 32'h40 + 32'(4 * $urandom_range(0, N - 1));
      endcase
      a = a | 32'($urandom_range(0, 3));
      d = (a[7:2] == 6'd5) ? 32'($urandom_range(0, 3)) : $urandom;
      bus.addr = a; bus.wdata = d; bus.wenable = ($urandom_range(0, 2) != 0);
      #1;
      chk("rand_rd", bus.rdata, m_read(a));
      step();
    end
    bus.wenable = 1'b0;

    // Async reset while outputs are lit
    wr(BASE + 32'h10, 32'h00);
    wr(BASE + 32'h00, 32'hFF);
    step();
    chk("pre_rst_led", 32'(led), 32'hFF);
    #5 reset_n = 1'b0;
    m_reset();
    #1;
    chk("async_led", 32'(led), 32'h0);
    rd("async_status", BASE + 32'h18);
    @(negedge clk_25mhz);
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin rd("post_rst", BASE + 32'h18); step(); end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : watchdog
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
